// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between three requesters and onehot_rr_arbiter.
// The master side drives requests and completion; the slave side is the arbiter.
interface onehot_rr_arbiter_if;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, owner, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, owner, busy, timeout
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Three-way round-robin arbiter with a one-hot IDLE/GRANT/RELEASE controller.
// Define ARB_TIMEOUT_EN to build the hold watchdog that forcibly reclaims long grants.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests in rotating order
// GRANT   | owner holds gnt until done/req drop (or watchdog expiry)
// RELEASE | one-cycle turnaround with gnt low; priority pointer rotates
module onehot_rr_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input logic                clock,
  input logic                reset,
  onehot_rr_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'b001;
  localparam logic [2:0] GRANT   = 3'b010;
  localparam logic [2:0] RELEASE = 3'b100;

  if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
    $error("onehot_rr_arbiter: TIMEOUT must be within 2..15");
  end

  logic [2:0] st, st_nxt;
  logic [2:0] last, last_nxt;
  logic [2:0] gnt_q, gnt_nxt;
  logic [1:0] owner_q, owner_nxt;
  logic       busy_q;
  logic [2:0] pick;
  logic [1:0] pick_idx;
  logic       owner_done, owner_req, normal_rel, expired;

  // gnt is the one-hot image of owner while in GRANT, so masking with it selects done/req[owner]
  assign owner_done = |(bus.done & gnt_q);
  assign owner_req  = |(bus.req & gnt_q);
  assign normal_rel = owner_done || !owner_req;

  always_comb begin
    pick = '0;
    case (last)
      3'b001: begin
        if (bus.req[1])      pick = 3'b010;
        else if (bus.req[2]) pick = 3'b100;
        else if (bus.req[0]) pick = 3'b001;
      end
      3'b010: begin
        if (bus.req[2])      pick = 3'b100;
        else if (bus.req[0]) pick = 3'b001;
        else if (bus.req[1]) pick = 3'b010;
      end
      default: begin
        if (bus.req[0])      pick = 3'b001;
        else if (bus.req[1]) pick = 3'b010;
        else if (bus.req[2]) pick = 3'b100;
      end
    endcase
    pick_idx = {pick[2], pick[1]};
  end

`ifdef ARB_TIMEOUT_EN
  logic [3:0] hold_cnt;
  logic       timeout_q, timeout_nxt;

  assign expired     = (hold_cnt == 4'(TIMEOUT - 1));
  // a same-edge done or req drop wins over expiry and is reported as a normal release
  assign timeout_nxt = st[1] && expired && !normal_rel;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_nxt;
      if (st[0])      hold_cnt <= '0;
      else if (st[1]) hold_cnt <= hold_cnt + 4'd1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expired     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      st      <= IDLE;
      last    <= 3'b100;
      gnt_q   <= '0;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      st      <= st_nxt;
      last    <= last_nxt;
      gnt_q   <= gnt_nxt;
      owner_q <= owner_nxt;
      busy_q  <= (st_nxt != IDLE);
    end
  end

  always_comb begin
    st_nxt = st;
    case (1'b1)
      st[0]:   if (|bus.req) st_nxt = GRANT;
      st[1]:   if (normal_rel || expired) st_nxt = RELEASE;
      st[2]:   st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt   = gnt_q;
    owner_nxt = owner_q;
    last_nxt  = last;
    case (1'b1)
      st[0]: begin
        gnt_nxt = pick;
        if (|bus.req) owner_nxt = pick_idx;
      end
      st[1]: if (normal_rel || expired) gnt_nxt = '0;
      st[2]: begin
        gnt_nxt  = '0;
        last_nxt = 3'b001 << owner_q;
      end
      default: gnt_nxt = '0;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter; expected values are hand-derived cycle by cycle.
// Watchdog scenarios are selected by ARB_TIMEOUT_EN, matching the RTL build.
module tb_onehot_rr_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2:0] order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  onehot_rr_arbiter_if bus();

  onehot_rr_arbiter #(.TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus.done = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    reset    = 1'b1;
    bus.req  = '0;
    bus.done = '0;
    step();
    step();
    chk("rst_gnt", {1'b0, bus.gnt}, 4'h0);
    chk("rst_owner", {2'b0, bus.owner}, 4'h0);
    chk("rst_busy", {3'b0, bus.busy}, 4'h0);
    chk("rst_timeout", {3'b0, bus.timeout}, 4'h0);
    reset = 1'b0;

    // single requester
    bus.req = 3'b010;
    step();
    chk("single_gnt_e1", {1'b0, bus.gnt}, 4'h2);
    chk("single_owner_e1", {2'b0, bus.owner}, 4'h1);
    chk("single_busy_e1", {3'b0, bus.busy}, 4'h1);
    step();
    step();
    chk("single_gnt_e3", {1'b0, bus.gnt}, 4'h2);
    bus.done = 3'b010;
    step();
    chk("single_gnt_e4", {1'b0, bus.gnt}, 4'h0);
    chk("single_busy_e4", {3'b0, bus.busy}, 4'h1);
    bus.done = '0;
    bus.req  = '0;
    step();
    chk("single_busy_e5", {3'b0, bus.busy}, 4'h0);
    chk("single_owner_kept", {2'b0, bus.owner}, 4'h1);

    // rotation with all requesting
    do_reset();
    bus.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rot_gnt", {1'b0, bus.gnt}, {1'b0, order[i]});
      chk("rot_owner", {2'b0, bus.owner}, (i == 3) ? 4'h0 : 4'(i));
      step();
      chk("rot_hold", {1'b0, bus.gnt}, {1'b0, order[i]});
      bus.done = order[i];
      step();
      chk("rot_gap0", {1'b0, bus.gnt}, 4'h0);
      bus.done = '0;
      step();
      chk("rot_gap1", {1'b0, bus.gnt}, 4'h0);
    end
    bus.req = '0;
    step();

    // foreign done ignored, req drop releases
    do_reset();
    bus.req = 3'b001;
    step();
    chk("foreign_gnt", {1'b0, bus.gnt}, 4'h1);
    bus.done = 3'b110;
    step();
    chk("foreign_hold1", {1'b0, bus.gnt}, 4'h1);
    step();
    chk("foreign_hold2", {1'b0, bus.gnt}, 4'h1);
    bus.done = '0;
    bus.req  = '0;
    step();
    chk("reqdrop_gnt", {1'b0, bus.gnt}, 4'h0);
    chk("reqdrop_busy", {3'b0, bus.busy}, 4'h1);
    step();
    chk("reqdrop_idle", {3'b0, bus.busy}, 4'h0);

    // reset mid-grant
    do_reset();
    bus.req = 3'b100;
    step();
    chk("midrst_gnt_pre", {1'b0, bus.gnt}, 4'h4);
    chk("midrst_owner_pre", {2'b0, bus.owner}, 4'h2);
    reset = 1'b1;
    step();
    chk("midrst_gnt", {1'b0, bus.gnt}, 4'h0);
    chk("midrst_owner", {2'b0, bus.owner}, 4'h0);
    chk("midrst_busy", {3'b0, bus.busy}, 4'h0);
    reset   = 1'b0;
    bus.req = 3'b101;
    step();
    chk("midrst_regnt", {1'b0, bus.gnt}, 4'h1);
    chk("midrst_regnt_owner", {2'b0, bus.owner}, 4'h0);
    bus.req = '0;
    step();
    step();

`ifdef ARB_TIMEOUT_EN
    // watchdog expiry with TIMEOUT = 4
    do_reset();
    bus.req = 3'b011;
    step();
    chk("wd_gnt_k", {1'b0, bus.gnt}, 4'h1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("wd_hold", {1'b0, bus.gnt}, 4'h1);
      chk("wd_no_pulse", {3'b0, bus.timeout}, 4'h0);
    end
    step();
    chk("wd_gnt_rel", {1'b0, bus.gnt}, 4'h0);
    chk("wd_pulse", {3'b0, bus.timeout}, 4'h1);
    chk("wd_busy_rel", {3'b0, bus.busy}, 4'h1);
    step();
    chk("wd_pulse_end", {3'b0, bus.timeout}, 4'h0);
    chk("wd_gap", {1'b0, bus.gnt}, 4'h0);
    step();
    chk("wd_next_gnt", {1'b0, bus.gnt}, 4'h2);
    chk("wd_next_owner", {2'b0, bus.owner}, 4'h1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("wd2_hold", {1'b0, bus.gnt}, 4'h2);
    end
    bus.done = 3'b010;
    step();
    chk("wd2_gnt_rel", {1'b0, bus.gnt}, 4'h0);
    chk("wd2_no_pulse", {3'b0, bus.timeout}, 4'h0);
    bus.done = '0;
    bus.req  = '0;
    step();
    chk("wd2_no_pulse_late", {3'b0, bus.timeout}, 4'h0);
`else
    // without the watchdog a grant is held indefinitely
    do_reset();
    bus.req = 3'b011;
    step();
    chk("hold_gnt", {1'b0, bus.gnt}, 4'h1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_forever", {1'b0, bus.gnt}, 4'h1);
      chk("hold_no_timeout", {3'b0, bus.timeout}, 4'h0);
    end
    bus.req = '0;
    step();
    chk("hold_release", {1'b0, bus.gnt}, 4'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that shares a single one-hot-sequenced resource among three requesters. It uses a one-hot controller (IDLE / GRANT / RELEASE) with a rotating one-hot priority pointer. It sits in front of a shared state machine or datapath and decides which requester may drive it, holding the grant until the owner signals completion. An optional watchdog forcibly reclaims a grant that is held too long.

## Interface
- `TIMEOUT`, default 8: GRANT cycles allowed before forced release; only used when `ARB_TIMEOUT_EN` is defined; legal range 2..15.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  [2:0]  request per requester; level-sensitive.
- `done`  in  [2:0]  per-requester completion strobe; sampled only for the current owner.
- `gnt`  out  [2:0]  one-hot grant, registered; all zero when no owner.
- `owner`  out  [1:0]  binary index of the last granted requester, registered.
- `busy`  out  1  high whenever state is not IDLE.
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- State register `st` is one-hot with three states: IDLE = 3'b001, GRANT = 3'b010, RELEASE = 3'b100. Next-state logic decodes with `case (1'b1)` on the state bits.
- `last` is a one-hot priority pointer. The search order starts at the requester after `last` and wraps 2→0.
- IDLE
  - If `|req`, choose the first set `req` bit in rotating order.
  - Go to GRANT, load `gnt` with that bit and `owner` with its index.
  - Otherwise stay in IDLE with `gnt` = 0.
- GRANT
  - `gnt` is held constant.
  - If `done[owner]` is 1 or `req[owner]` is 0, go to RELEASE.
  - `done` bits of non-owners are ignored.
- RELEASE
  - `gnt` = 0 for exactly one cycle (turnaround).
  - `last` is loaded with the released grant.
  - Go to IDLE.
- Reset values: `st` = IDLE, `gnt` = 3'b000, `owner` = 2'd0, `busy` = 0, `timeout` = 0, `last` = 3'b100 (so requester 0 has top priority first), hold counter = 0.
- Only one `gnt` bit is ever set. `gnt` is never nonzero outside GRANT.
- `owner` keeps its value through RELEASE and IDLE; it changes only when a new grant is issued.

## Timing
- Grant latency: `req` seen at edge k while in IDLE gives `gnt` high after edge k.
- Release: `done` seen at edge n while in GRANT gives `gnt` low after edge n. The state is RELEASE after edge n and IDLE after edge n+1.
- Earliest re-grant is after edge n+2. Back-to-back owners therefore see a 2-cycle gap with `gnt` = 0.
- A requester asserting during GRANT or RELEASE waits and is arbitrated on the first IDLE edge.
- If `done[owner]` is asserted on the same edge that GRANT is entered, it is not seen; it is first sampled on the following edge.
- `reset` asserted in any state: all registers take their reset values on that edge, and `gnt` drops immediately after it.
- `busy` is registered; it is 1 for GRANT and RELEASE cycles.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - A 4-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches `TIMEOUT`-1 without release, force RELEASE and pulse `timeout` for the cycle in which the state is RELEASE.
  - If `done[owner]` and expiry occur on the same edge, treat it as a normal release; `timeout` stays 0.
  - A timed-out owner is still rotated to lowest priority.
- Not defined: no counter is built, `timeout` is tied to 0, and GRANT is held indefinitely until `done[owner]` or `req[owner]` drops.

## Test plan
- Reset then single requester: `req` = 3'b010 at edge 1 → `gnt` = 3'b010 and `owner` = 1 after edge 1; `done` = 3'b010 at edge 4 → `gnt` = 0 after edge 4, `busy` = 0 after edge 5.
- Rotation: `req` = 3'b111 held, each owner pulses `done` 2 cycles after its grant → grant order 001, 010, 100, 001 with a 2-cycle `gnt` = 0 gap between each.
- Foreign done ignored: owner 0 granted, `done` = 3'b110 → `gnt` stays 3'b001; then `req[0]` drops → RELEASE on that edge.
- Reset mid-grant: `gnt` = 3'b100, `reset` = 1 for one edge → `gnt` = 0, `owner` = 0, `st` = IDLE; then `req` = 3'b101 → requester 0 is granted.
- With `ARB_TIMEOUT_EN` and `TIMEOUT` = 4: owner never asserts `done` → `gnt` held exactly 4 cycles, then `timeout` = 1 for one cycle and the next requester is granted 2 cycles later. Repeating with `done` on the expiry edge → `timeout` stays 0.
